key_loader: RTL and testbench

KEY_LOADER -- requirements
Module: key_loader

---
 rtl/key_loader.sv | 158 +++++++++++++++
 tb/tb_key_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_loader.sv
// Serial key loader for a logic-locked netlist: shifts in a parity-protected
// key frame, presents the key only after the parity check, locks out after repeated failures.
module key_loader #(
  parameter int unsigned KEY_W    = 12,
  parameter int unsigned MAX_FAIL = 3,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_start,
  input  logic             key_sdi,
  input  logic             key_sdi_vld,
  output logic [KEY_W-1:0] key_out,
  output logic             key_ok,
  output logic             key_err,
  output logic             busy,
  output logic             locked_out
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned FC_W  = $clog2(MAX_FAIL + 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    DONE,
    FAIL,
    LOCKOUT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [KEY_W:0]     sr_q, sr_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [FC_W-1:0]    fail_cnt_q, fail_cnt_d;
  logic [KEY_W-1:0]   key_out_q, key_out_d;
  logic               key_ok_q, key_ok_d;
  logic               key_err_q, key_err_d;
  logic               busy_q, busy_d;
  logic               locked_q, locked_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    timer_d    = timer_q;
    fail_cnt_d = fail_cnt_q;

    case (state_q)
      IDLE: begin
        if (key_start) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          sr_d      = '0;
          timer_d   = '0;
        end
      end
      SHIFT: begin
        if (key_start) begin
          // Restart: a bit qualified in the same cycle becomes bit 0 of the new frame.
          sr_d      = '0;
          timer_d   = '0;
          bit_cnt_d = '0;
          if (key_sdi_vld) begin
            sr_d[0]   = key_sdi;
            bit_cnt_d = CNT_W'(1);
          end
        end else if (key_sdi_vld) begin
          sr_d[bit_cnt_q] = key_sdi;
          timer_d         = '0;
          if (bit_cnt_q == CNT_W'(KEY_W)) begin
            state_d = CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          if (timer_q != TMR_W'(TIMEOUT)) begin
            timer_d = timer_q + 1'b1;
          end
          if (timer_q >= TMR_W'(TIMEOUT - 1)) begin
            state_d = FAIL;
          end
        end
      end
      CHECK: begin
        if (^sr_q) begin
          state_d = FAIL;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      FAIL: begin
        if (fail_cnt_q != FC_W'(MAX_FAIL)) begin
          fail_cnt_d = fail_cnt_q + 1'b1;
        end
        if (fail_cnt_d == FC_W'(MAX_FAIL)) begin
          state_d = LOCKOUT;
        end else begin
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        state_d = LOCKOUT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with the state register.
    key_out_d = '0;
    if (state_d == DONE) begin
      key_out_d = (state_q == CHECK) ? sr_q[KEY_W-1:0] : key_out_q;
    end
    key_ok_d  = (state_d == DONE);
    key_err_d = (state_d == FAIL);
    busy_d    = (state_d == SHIFT) || (state_d == CHECK);
    locked_d  = (state_d == LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      timer_q    <= '0;
      fail_cnt_q <= '0;
      key_out_q  <= '0;
      key_ok_q   <= 1'b0;
      key_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      timer_q    <= timer_d;
      fail_cnt_q <= fail_cnt_d;
      key_out_q  <= key_out_d;
      key_ok_q   <= key_ok_d;
      key_err_q  <= key_err_d;
      busy_q     <= busy_d;
      locked_q   <= locked_d;
    end
  end

  assign key_out    = key_out_q;
  assign key_ok     = key_ok_q;
  assign key_err    = key_err_q;
  assign busy       = busy_q;
  assign locked_out = locked_q;

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: directed frames with literal expectations plus
// randomized frames compared every cycle against a queue-based reference model.
module tb_key_loader;

  localparam int KW = 12;
  localparam int MF = 3;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_start = 1'b0;
  logic          key_sdi = 1'b0;
  logic          key_sdi_vld = 1'b0;
  logic [KW-1:0] key_out;
  logic          key_ok;
  logic          key_err;
  logic          busy;
  logic          locked_out;

  int checks = 0;
  int passes = 0;

  key_loader #(.KEY_W(KW), .MAX_FAIL(MF), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_start  (key_start),
    .key_sdi    (key_sdi),
    .key_sdi_vld(key_sdi_vld),
    .key_out    (key_out),
    .key_ok     (key_ok),
    .key_err    (key_err),
    .busy       (busy),
    .locked_out (locked_out)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
  endtask

  task automatic chkk(input string name, input logic [KW-1:0] got, input logic [KW-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: collected frame bits, idle count, failure tally and outcome flags.
  bit          m_bits[$];
  int          m_idle = 0;
  int          m_fails = 0;
  bit          m_in_frame = 0;
  bit          m_check = 0;
  bit          m_err = 0;
  bit          m_done = 0;
  bit          m_locked = 0;
  logic [KW-1:0] m_key = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_bits.delete();
      m_idle = 0; m_fails = 0; m_in_frame = 0; m_check = 0;
      m_err = 0; m_done = 0; m_locked = 0; m_key = '0;
    end else if (m_done || m_locked) begin
      // terminal until reset
    end else if (m_err) begin
      m_err = 0;
      m_fails++;
      if (m_fails >= MF) m_locked = 1;
    end else if (m_check) begin
      bit p;
      p = 0;
      m_check = 0;
      foreach (m_bits[i]) p ^= m_bits[i];
      if (p == 0) begin
        m_done = 1;
        for (int i = 0; i < KW; i++) m_key[i] = m_bits[i];
      end else begin
        m_err = 1;
      end
    end else if (m_in_frame) begin
      if (key_start) begin
        m_bits.delete();
        m_idle = 0;
        if (key_sdi_vld) m_bits.push_back(key_sdi);
      end else if (key_sdi_vld) begin
        m_bits.push_back(key_sdi);
        m_idle = 0;
        if (m_bits.size() == KW + 1) begin
          m_in_frame = 0;
          m_check = 1;
        end
      end else begin
        m_idle++;
        if (m_idle >= TO) begin
          m_in_frame = 0;
          m_err = 1;
        end
      end
    end else if (key_start) begin
      m_in_frame = 1;
      m_bits.delete();
      m_idle = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    chkk("key_out", key_out, m_done ? m_key : '0);
    chk1("key_ok", key_ok, m_done);
    chk1("key_err", key_err, m_err);
    chk1("busy", busy, m_in_frame | m_check);
    chk1("locked_out", locked_out, m_locked);
  end

  task automatic drive(input logic s, input logic v, input logic d);
    @(negedge clk);
    key_start = s;
    key_sdi_vld = v;
    key_sdi = d;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [KW-1:0] k, input logic par);
    for (int i = 0; i < KW; i++) drive(1'b0, 1'b1, k[i]);
    drive(1'b0, 1'b1, par);
  endtask

  task automatic do_reset(input logic start_after);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chkk("rst_key_out", key_out, '0);
    chk1("rst_key_ok", key_ok, 1'b0);
    chk1("rst_key_err", key_err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_locked", locked_out, 1'b0);
    key_start = 1'b0;
    key_sdi_vld = 1'b0;
    key_sdi = 1'b0;
    @(negedge clk);
    #2;
    key_start = start_after;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [KW-1:0] k;
    logic par;
    int gap;

    repeat (3) @(negedge clk);
    do_reset(1'b0);

    // Good 0xA5C frame: key_ok two edges after the parity bit; DONE ignores inputs.
    drive(1'b1, 1'b0, 1'b0);
    send_frame(12'hA5C, 1'b0);
    after_edge();
    chk1("check_busy", busy, 1'b1);
    chk1("check_key_ok", key_ok, 1'b0);
    chkk("check_key_out", key_out, 12'h000);
    after_edge();
    chk1("done_key_ok", key_ok, 1'b1);
    chkk("done_key_out", key_out, 12'hA5C);
    chk1("done_busy", busy, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    after_edge();
    chkk("done_hold", key_out, 12'hA5C);

    // Asynchronous reset from DONE, start accepted on the first edge after release.
    do_reset(1'b1);
    after_edge();
    chk1("start_first_edge", busy, 1'b1);
    send_frame(12'hA5C, 1'b0);
    after_edge();
    after_edge();
    chkk("reload_key_out", key_out, 12'hA5C);

    // Three bad-parity frames lead to lockout; a later good frame is ignored.
    do_reset(1'b0);
    for (int f = 0; f < 3; f++) begin
      drive(1'b1, 1'b0, 1'b0);
      send_frame(12'hA5C, 1'b1);
      after_edge();
      after_edge();
      chk1("bad_key_err", key_err, 1'b1);
      chkk("bad_key_out", key_out, 12'h000);
      after_edge();
      chk1("bad_err_one_cycle", key_err, 1'b0);
      chk1("bad_locked", locked_out, (f == 2) ? 1'b1 : 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0);
    send_frame(12'hA5C, 1'b0);
    after_edge();
    after_edge();
    chk1("lockout_key_ok", key_ok, 1'b0);
    chk1("lockout_busy", busy, 1'b0);
    chk1("lockout_locked", locked_out, 1'b1);

    // Timeout after 5 bits and 64 idle cycles counts as one failure.
    do_reset(1'b0);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'($urandom));
    repeat (TO - 1) drive(1'b0, 1'b0, 1'b0);
    after_edge();
    chk1("timeout_not_yet", key_err, 1'b0);
    chk1("timeout_busy", busy, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    after_edge();
    chk1("timeout_err", key_err, 1'b1);
    after_edge();
    chk1("timeout_idle", busy, 1'b0);
    for (int f = 0; f < 2; f++) begin
      drive(1'b1, 1'b0, 1'b0);
      send_frame(12'hA5C, 1'b1);
      repeat (3) after_edge();
    end
    chk1("timeout_counted", locked_out, 1'b1);

    // Mid-frame restart, then a good 0x3F0 frame.
    do_reset(1'b0);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'($urandom));
    drive(1'b1, 1'b0, 1'b0);
    send_frame(12'h3F0, 1'b0);
    after_edge();
    after_edge();
    chkk("restart_key_out", key_out, 12'h3F0);
    chk1("restart_key_ok", key_ok, 1'b1);

    // Restart with a qualified bit in the same cycle: that bit is bit 0.
    do_reset(1'b0);
    k = 12'h123;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, k[0]);
    for (int i = 1; i < KW; i++) drive(1'b0, 1'b1, k[i]);
    drive(1'b0, 1'b1, 1'b0);
    after_edge();
    after_edge();
    chkk("restart_vld_key_out", key_out, 12'h123);

    // Randomized frames: gaps, occasional timeouts, restarts and bad parity.
    for (int ep = 0; ep < 30; ep++) begin
      do_reset(1'b0);
      repeat ($urandom_range(2, 5)) begin
        repeat ($urandom_range(0, 3)) drive(1'b0, 1'($urandom), 1'($urandom));
        drive(1'b1, 1'($urandom), 1'($urandom));
        k = KW'($urandom);
        par = (^k) ^ (($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        for (int i = 0; i <= KW; i++) begin
          if ($urandom_range(0, 39) == 0) gap = TO - 1 + int'($urandom_range(0, 2));
          else gap = int'($urandom_range(0, 2));
          repeat (gap) drive(1'b0, 1'b0, 1'($urandom));
          if ($urandom_range(0, 29) == 0) drive(1'b1, 1'($urandom), 1'($urandom));
          drive(1'b0, 1'b1, (i == KW) ? par : k[i]);
        end
        repeat (3) drive(1'b0, 1'($urandom), 1'($urandom));
      end
    end

    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
